// File: rtl/seq_restoring_divider.sv
// ----------------------------------------------------------------------------
// seq_restoring_divider
//
// Multi-cycle unsigned divider: quotient = dividend / divisor and
// remainder = dividend % divisor. One restoring-division iteration runs per
// clock. Every iteration uses the same (N+1)-bit subtractor instance.
//
// Handshake:
//   - start is sampled only in IDLE.
//   - busy is high while the iteration loop runs.
//   - done pulses for one cycle when results are updated.
//   - A zero divisor skips the loop. The unit reports quotient = all ones,
//     remainder = dividend and div_by_zero = 1, with done one cycle later.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous, active-high reset
//   start        in   operation request, sampled only in IDLE
//   dividend     in   [N-1:0] numerator, captured on an accepted start
//   divisor      in   [N-1:0] denominator, captured on an accepted start
//   busy         out  high while iterating
//   done         out  one-cycle completion pulse
//   quotient     out  [N-1:0] result, held until the next completion
//   remainder    out  [N-1:0] result, held until the next completion
//   div_by_zero  out  flag for the last completed operation
// ----------------------------------------------------------------------------

// ----------------------------------------------------------------------------
// subtractor_parallel
//
// Word-wide subtractor with borrow in and borrow out:
//   {bout, diff} = a - b - bin
// bout is set when the true result is negative.
//
// Ports:
//   a     in   [W-1:0] minuend
//   b     in   [W-1:0] subtrahend
//   bin   in   borrow in
//   diff  out  [W-1:0] difference modulo 2**W
//   bout  out  borrow out
// ----------------------------------------------------------------------------
module subtractor_parallel #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] diff,
    output logic         bout
);

    // The subtraction is done one bit wider than the operands. A negative
    // result wraps, which leaves the extra MSB set; that MSB is the borrow.
    logic [W:0] wide;

    assign wide = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    assign diff = wide[W-1:0];
    assign bout = wide[W];

endmodule

module seq_restoring_divider #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Iteration state: partial remainder, the shift register holding the
    // unconsumed dividend bits / built-up quotient bits, the captured
    // divisor and the iteration counter.
    logic [N-1:0]     r_reg;
    logic [N-1:0]     q_reg;
    logic [N-1:0]     divisor_reg;
    logic [CNT_W-1:0] count;

    // Shared subtractor signals.
    logic [N:0] trial;
    logic [N:0] sub_diff;
    logic       sub_bout;
    logic       unused_diff_msb;

    logic [N-1:0] r_next;
    logic [N-1:0] q_next;
    logic         last_iter;
    logic         accept;
    logic         divisor_zero;

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    // Shift the next dividend bit into the partial remainder, then try to
    // subtract the divisor.
    assign trial = {r_reg, q_reg[N-1]};

    subtractor_parallel #(
        .W (N + 1)
    ) u_sub (
        .a    (trial),
        .b    ({1'b0, divisor_reg}),
        .bin  (1'b0),
        .diff (sub_diff),
        .bout (sub_bout)
    );

    // When there is no borrow, trial < 2*divisor. The difference then fits
    // in N bits, so its MSB carries no information.
    assign unused_diff_msb = sub_diff[N];

    // No borrow: keep the difference and emit a 1 quotient bit.
    // Borrow: restore the shifted remainder and emit a 0 quotient bit.
    assign r_next = sub_bout ? trial[N-1:0] : sub_diff[N-1:0];
    assign q_next = {q_reg[N-2:0], ~sub_bout};

    assign last_iter    = (count == LAST_ITER);
    assign divisor_zero = (divisor == '0);
    assign accept       = (state == IDLE) && start;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = divisor_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Status outputs are decoded from the registered state, so they are
    // glitch-free and change only on a clock edge.
    assign busy = (state == CALC);
    assign done = (state == DONE);

    // ------------------------------------------------------------------
    // Iteration registers and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg       <= '0;
            q_reg       <= '0;
            divisor_reg <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (divisor_zero) begin
                            // Skip the loop and publish the fixed
                            // divide-by-zero result immediately.
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            divisor_reg <= divisor;
                            q_reg       <= dividend;
                            r_reg       <= '0;
                            count       <= '0;
                        end
                    end
                end
                CALC: begin
                    r_reg <= r_next;
                    q_reg <= q_next;
                    count <= count + CNT_W'(1);
                    if (last_iter) begin
                        quotient    <= q_next;
                        remainder   <= r_next;
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                    // DONE: results are already published. Nothing to update.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// ----------------------------------------------------------------------------
// tb_seq_restoring_divider
//
// Self-checking bench for seq_restoring_divider with N = 8.
// Expected results come from plain integer / and % on the operands. A zero
// divisor gives quotient = all ones and remainder = dividend. Expected timing
// comes from the documented latencies:
//   - N+1 cycles normally;
//   - 1 cycle for divide-by-zero;
//   - a back-to-back period of N+2 cycles.
//
// Inputs are driven on the falling edge and outputs are sampled on the
// falling edge, away from the active rising edge.
// ----------------------------------------------------------------------------
module tb_seq_restoring_divider;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    int checks;
    int failures;

    // Results the DUT should currently be holding.
    logic [N-1:0] prev_q;
    logic [N-1:0] prev_r;
    logic         prev_z;

    seq_restoring_divider #(
        .N (N)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic.
    function automatic logic [N-1:0] ref_q(input logic [N-1:0] a, input logic [N-1:0] b);
        int unsigned ai;
        int unsigned bi;
        ai = a;
        bi = b;
        if (bi == 0) return {N{1'b1}};
        return N'(ai / bi);
    endfunction

    function automatic logic [N-1:0] ref_r(input logic [N-1:0] a, input logic [N-1:0] b);
        int unsigned ai;
        int unsigned bi;
        ai = a;
        bi = b;
        if (bi == 0) return a;
        return N'(ai % bi);
    endfunction

    // Runs one operation. The task starts and ends just after a falling edge,
    // with the DUT in IDLE.
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input string name);
        logic [N-1:0] exp_q;
        logic [N-1:0] exp_r;
        logic         exp_z;
        int           exp_lat;
        int           cycles;
        exp_q   = ref_q(a, b);
        exp_r   = ref_r(a, b);
        exp_z   = (b == '0);
        exp_lat = exp_z ? 1 : N + 1;

        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        cycles = 1;
        start  = 1'b0;

        while (done !== 1'b1 && cycles < 20) begin
            checks++;
            if (busy !== !exp_z) begin
                failures++;
                $display("FAIL %s busy cyc=%0d got=%b want=%b", name, cycles, busy, !exp_z);
            end
            checks++;
            if (quotient !== prev_q || remainder !== prev_r || div_by_zero !== prev_z) begin
                failures++;
                $display("FAIL %s hold cyc=%0d got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b",
                         name, cycles, quotient, remainder, div_by_zero, prev_q, prev_r, prev_z);
            end
            // Operand changes in flight must not affect the result.
            dividend = N'($urandom);
            divisor  = N'($urandom);
            @(negedge clk);
            cycles++;
        end

        checks++;
        if (cycles !== exp_lat) begin
            failures++;
            $display("FAIL %s latency got=%0d want=%0d", name, cycles, exp_lat);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s busy_at_done got=%b want=0", name, busy);
        end
        checks++;
        if (quotient !== exp_q) begin
            failures++;
            $display("FAIL %s quotient a=%0d b=%0d got=%0d want=%0d", name, a, b, quotient, exp_q);
        end
        checks++;
        if (remainder !== exp_r) begin
            failures++;
            $display("FAIL %s remainder a=%0d b=%0d got=%0d want=%0d", name, a, b, remainder, exp_r);
        end
        checks++;
        if (div_by_zero !== exp_z) begin
            failures++;
            $display("FAIL %s div_by_zero got=%b want=%b", name, div_by_zero, exp_z);
        end

        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL %s done_width got=%b want=0", name, done);
        end
        checks++;
        if (quotient !== exp_q || remainder !== exp_r || div_by_zero !== exp_z) begin
            failures++;
            $display("FAIL %s post_hold got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b",
                     name, quotient, remainder, div_by_zero, exp_q, exp_r, exp_z);
        end
        prev_q = exp_q;
        prev_r = exp_r;
        prev_z = exp_z;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_status got busy=%b done=%b want 0 0", busy, done);
        end
        checks++;
        if (quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL reset_results got q=%0d r=%0d z=%b want 0 0 0",
                     quotient, remainder, div_by_zero);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got busy=%b done=%b want 0 0", busy, done);
        end
        prev_q = '0;
        prev_r = '0;
        prev_z = 1'b0;
    endtask

    task automatic test_directed();
        do_op(8'd100, 8'd7,   "d_100_7");
        do_op(8'd255, 8'd1,   "d_255_1");
        do_op(8'd5,   8'd9,   "d_5_9");
        do_op(8'd255, 8'd255, "d_255_255");
        do_op(8'd0,   8'd13,  "d_0_13");
        do_op(8'd77,  8'd0,   "d_77_0");
        do_op(8'd10,  8'd3,   "d_10_3");
    endtask

    // start stays high and the operands change every cycle. Divisors are
    // nonzero, so an op is accepted every N+2 edges and each result must
    // match the operands present at that op's accept edge.
    task automatic test_back_to_back();
        logic [N-1:0] a_hist [0:49];
        logic [N-1:0] b_hist [0:49];
        int           ph;
        logic         exp_done;
        logic         exp_busy;
        start = 1'b1;
        for (int cyc = 0; cyc < 50; cyc++) begin
            a_hist[cyc] = N'($urandom);
            b_hist[cyc] = N'($urandom_range(1, 255));
            dividend    = a_hist[cyc];
            divisor     = b_hist[cyc];
            @(negedge clk);
            ph       = cyc % (N + 2);
            exp_busy = (ph < N);
            exp_done = (ph == N);
            checks++;
            if (busy !== exp_busy || done !== exp_done) begin
                failures++;
                $display("FAIL b2b_status cyc=%0d got busy=%b done=%b want busy=%b done=%b",
                         cyc, busy, done, exp_busy, exp_done);
            end
            if (exp_done) begin
                checks++;
                if (quotient !== ref_q(a_hist[cyc-N], b_hist[cyc-N]) ||
                    remainder !== ref_r(a_hist[cyc-N], b_hist[cyc-N])) begin
                    failures++;
                    $display("FAIL b2b_result cyc=%0d a=%0d b=%0d got q=%0d r=%0d want q=%0d r=%0d",
                             cyc, a_hist[cyc-N], b_hist[cyc-N], quotient, remainder,
                             ref_q(a_hist[cyc-N], b_hist[cyc-N]),
                             ref_r(a_hist[cyc-N], b_hist[cyc-N]));
                end
                prev_q = ref_q(a_hist[cyc-N], b_hist[cyc-N]);
                prev_r = ref_r(a_hist[cyc-N], b_hist[cyc-N]);
                prev_z = 1'b0;
            end
        end
        // The last loop edge has returned the DUT to IDLE.
        start = 1'b0;
    endtask

    task automatic test_reset_mid_calc();
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL midrst_status got busy=%b done=%b want 0 0", busy, done);
        end
        checks++;
        if (quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL midrst_results got q=%0d r=%0d z=%b want 0 0 0",
                     quotient, remainder, div_by_zero);
        end
        prev_q = '0;
        prev_r = '0;
        prev_z = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL midrst_no_done i=%0d got busy=%b done=%b want 0 0", i, busy, done);
            end
        end
        do_op(8'd200, 8'd3, "midrst_200_3");
    endtask

    task automatic test_random();
        logic [N-1:0] a;
        logic [N-1:0] b;
        for (int i = 0; i < 1000; i++) begin
            a = N'($urandom);
            if ($urandom_range(0, 7) == 0) b = '0;
            else b = N'($urandom);
            do_op(a, b, "rand");
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        prev_q   = '0;
        prev_r   = '0;
        prev_z   = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_calc();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Multi-cycle unsigned integer divider: Q = dividend / divisor, R = dividend % divisor.
- Built around one shared (N+1)-bit subtractor_parallel instance (Bin tied 0), sequenced by an FSM over N iterations of restoring division.
- Sits beside the arithmetic datapath as its first sequential consumer; the start/busy/done handshake is reused by later multi-cycle units.

Parameters:
- N, 8, operand/quotient/remainder width; legal N >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset: synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- dividend  in  N  numerator, captured on accepted start.
- divisor  in  N  denominator, captured on accepted start.
- busy  out  1  high while state is CALC.
- done  out  1  high for exactly one cycle while state is DONE.
- quotient  out  N  result; held until next completion.
- remainder  out  N  result; held until next completion.
- div_by_zero  out  1  flag for last completed op; held with results.

Behaviour:
- One clock domain. rst is synchronous, active-high. rst=1 at any edge forces:
  - state IDLE;
  - busy, done, div_by_zero, quotient and remainder all 0;
  - internal R, Q and count all 0.
- Reset mid-CALC aborts the operation. No done pulse follows.
- States: IDLE, CALC, DONE. busy=(state==CALC), done=(state==DONE), both decoded from registered state.
- IDLE:
  - At an edge with start=1 and divisor!=0 (edge E0): latch divisor; Q<=dividend; R<=0; count<=0; state->CALC.
  - At an edge with start=1 and divisor==0: quotient<={N{1}}, remainder<=dividend, div_by_zero<=1, state->DONE. done is high in the cycle after E0.
  - start=0: stay in IDLE.
- CALC, one iteration per edge (E1..EN):
  - T = {R, Q[N-1]} is N+1 bits.
  - D, Bout = T - {1'b0, divisor} via the subtractor instance.
  - Bout==0: R<=D[N-1:0], Q<={Q[N-2:0],1'b1}.
  - Bout==1: R<=T[N-1:0], Q<={Q[N-2:0],1'b0}.
  - count increments. On the edge where count==N-1 (EN): quotient<=next Q, remainder<=next R, div_by_zero<=0, state->DONE.
- DONE: lasts exactly one cycle, then ->IDLE unconditionally.
- Latency, start edge to done visible:
  - N+1 cycles normally; done is high between EN and EN+1.
  - 1 cycle for divide-by-zero.
- start while busy or done is ignored; no queuing.
- Throughput: a start held high is accepted at the first IDLE edge after DONE. Back-to-back period is N+2 cycles.
- dividend/divisor changes after E0 have no effect on the operation in flight.
- quotient, remainder and div_by_zero change only at completion (or on rst). They are stable during CALC and IDLE.
- Invariant for divisor!=0: quotient*divisor + remainder == dividend, and remainder < divisor.

Test Plan (N=8):
- Reset, then start with 100/7 -> busy high for 8 cycles; done pulses once, 9 cycles after the start edge; quotient=14, remainder=2, div_by_zero=0.
- 255/1 -> quotient=255, remainder=0. 5/9 -> quotient=0, remainder=5. 255/255 -> quotient=1, remainder=0.
- 77/0 -> done 1 cycle after the start edge; quotient=0xFF, remainder=77, div_by_zero=1, busy never high. Then 10/3 -> quotient=3, remainder=1, div_by_zero cleared.
- Hold start=1 continuously, changing operands each cycle -> each accepted op's results match the operands captured at its IDLE edge; done pulses every 10 cycles; mid-CALC operand changes are ignored.
- Assert rst during CALC iteration 4 of 200/3 -> next cycle: busy=0, done=0, outputs 0. A following 200/3 -> quotient=66, remainder=2.
- Random sweep of 1000 pairs, including divisor=0 -> scoreboard checks quotient, remainder and div_by_zero, plus exact done timing and the single-cycle done pulse width.
